// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between the datapath and a word-addressed data memory
//
// Purpose:
//   Accepts one load or store request at a time, decodes the RISC-V funct3
//   size/sign field, and drives a word-addressed data memory. Loads extract
//   and extend a byte, halfword or word lane. Byte and halfword stores use a
//   read-modify-write of the containing word; word stores write directly.
//   Misaligned accesses and illegal funct3 codes complete with an error
//   response and never touch memory.
//
// Optional feature (macro MAU_ACCESS_COUNT_EN):
//   When defined, adds o_ld_count, o_st_count and o_err_count (16-bit
//   wrapping counters of successful loads, successful stores and errored
//   requests). When undefined those ports and registers do not exist.
//
// Ports:
//   i_clk          system clock, all state updates on posedge
//   i_reset        synchronous active-high reset
//   i_req_valid    request present (held by the requester until accepted)
//   o_req_ready    unit idle and able to accept a request
//   i_req_write    1 = store, 0 = load
//   i_req_addr     byte address
//   i_req_wdata    store data (low bits used for SB/SH)
//   i_req_funct3   size/sign code
//   o_resp_valid   one-cycle completion pulse
//   o_resp_rdata   extended load data, 0 for stores and errors
//   o_resp_err     misaligned or illegal funct3, qualified by o_resp_valid
//   o_dmem_addr    word-aligned memory address
//   o_dmem_din     memory write data
//   o_dmem_read    memory read enable
//   o_dmem_write   memory write enable (memory commits on the negedge)
//   i_dmem_dout    asynchronous memory read data
//   o_ld_count     successful loads        (MAU_ACCESS_COUNT_EN only)
//   o_st_count     successful stores       (MAU_ACCESS_COUNT_EN only)
//   o_err_count    errored requests        (MAU_ACCESS_COUNT_EN only)

module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [2:0]        i_req_funct3,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_din,
  output logic              o_dmem_read,
  output logic              o_dmem_write,
  input  logic [31:0]       i_dmem_dout
`ifdef MAU_ACCESS_COUNT_EN
  ,
  output logic [15:0]       o_ld_count,
  output logic [15:0]       o_st_count,
  output logic [15:0]       o_err_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;
  logic [ADDR_W-1:0]   r_dmem_addr;
  logic [31:0]         r_dmem_din;
  logic                r_dmem_read;

  // Captured request fields needed after the accept cycle.
  logic                r_write;
  logic [1:0]          r_off;
  logic [2:0]          r_funct3;
  logic [15:0]         r_wdata;

  logic                w_accept;
  logic                w_req_err;
  logic [31:0]         w_load_data;
  logic [31:0]         w_merge_data;

  // Error decode on the incoming request. Loads allow 000,001,010,100,101;
  // stores allow only 000,001,010. Halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic f_req_err(input logic       write,
                                     input logic [1:0] off,
                                     input logic [2:0] f3);
    logic err;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = off[0];
      3'b010:  err = |off;
      3'b100:  err = write;
      3'b101:  err = write | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Little-endian lane extraction with sign or zero extension.
  function automatic logic [31:0] f_load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b100:  v = {24'd0, b};
      3'b101:  v = {16'd0, h};
      default: v = word;
    endcase
    return v;
  endfunction

  // Replace the addressed byte or halfword lane of the word read back from
  // memory; every other byte is carried through unchanged.
  function automatic logic [31:0] f_store_merge(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3,
                                                input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00) begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  always_comb begin
    w_accept     = i_req_valid && r_req_ready;
    w_req_err    = f_req_err(i_req_write, i_req_addr[1:0], i_req_funct3);
    w_load_data  = f_load_extract(i_dmem_dout, r_off, r_funct3);
    w_merge_data = f_store_merge(i_dmem_dout, r_off, r_funct3, r_wdata);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_din   <= 32'd0;
      r_dmem_read  <= 1'b0;
      r_write      <= 1'b0;
      r_off        <= 2'd0;
      r_funct3     <= 3'd0;
      r_wdata      <= 16'd0;
    end else begin
      // Pulsed outputs default low; states that need them set them again.
      r_resp_valid <= 1'b0;
      r_dmem_read  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_write     <= i_req_write;
            r_off       <= i_req_addr[1:0];
            r_funct3    <= i_req_funct3;
            r_wdata     <= i_req_wdata[15:0];
            if (w_req_err) begin
              // Errors skip memory entirely and respond next cycle.
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_dmem_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
              if (!i_req_write) begin
                r_state     <= S_LOAD;
                r_dmem_read <= 1'b1;
              end else if (i_req_funct3[1:0] == 2'b10) begin
                r_state    <= S_WRITE;
                r_dmem_din <= i_req_wdata;
              end else begin
                r_state     <= S_RMW_RD;
                r_dmem_read <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load_data;
        end
        S_RMW_RD: begin
          r_state    <= S_WRITE;
          r_dmem_din <= w_merge_data;
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MAU_ACCESS_COUNT_EN
  logic [15:0] r_ld_count;
  logic [15:0] r_st_count;
  logic [15:0] r_err_count;

  // Counted once per response, in the RESP cycle; 16-bit adds wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ld_count  <= 16'd0;
      r_st_count  <= 16'd0;
      r_err_count <= 16'd0;
    end else if (r_state == S_RESP) begin
      if (r_resp_err) begin
        r_err_count <= r_err_count + 16'd1;
      end else if (r_write) begin
        r_st_count <= r_st_count + 16'd1;
      end else begin
        r_ld_count <= r_ld_count + 16'd1;
      end
    end
  end

  assign o_ld_count  = r_ld_count;
  assign o_st_count  = r_st_count;
  assign o_err_count = r_err_count;
`endif

  // The write strobe is gated by reset so a reset landing in WRITE cancels
  // the memory commit that would otherwise happen on this cycle's negedge.
  assign o_dmem_write = (r_state == S_WRITE) && !i_reset;
  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_din   = r_dmem_din;
  assign o_dmem_read  = r_dmem_read;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit

module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_din;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_dout;
`ifdef MAU_ACCESS_COUNT_EN
  logic [15:0] ld_count;
  logic [15:0] st_count;
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_funct3 (req_funct3),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_din   (dmem_din),
    .o_dmem_read  (dmem_read),
    .o_dmem_write (dmem_write),
    .i_dmem_dout  (dmem_dout)
`ifdef MAU_ACCESS_COUNT_EN
    ,
    .o_ld_count   (ld_count),
    .o_st_count   (st_count),
    .o_err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-word memory, aliased on address bits [7:2]; commits on negedge.
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_idx = 6'd0;
  logic [31:0] tb_wd = 32'd0;
  logic [31:0] exp_addr = 32'd0;

  assign dmem_dout = mem[dmem_addr[7:2]];

  always @(negedge clk) begin
    if (dmem_write) mem[dmem_addr[7:2]] <= dmem_din;
    else if (tb_we) mem[tb_idx] <= tb_wd;
  end

  // Every memory access must target the aligned address of the request in
  // flight, and read/write must never be asserted together.
  always @(negedge clk) begin
    if (!reset && (dmem_read || dmem_write)) begin
      checks++;
      if (dmem_addr !== exp_addr || (dmem_read && dmem_write)) begin
        failures++;
        $display("FAIL dmem_access actual addr=%h rd=%b wr=%b required addr=%h exclusive", dmem_addr, dmem_read, dmem_write, exp_addr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    tb_idx = idx[5:0];
    tb_wd  = val;
    tb_we  = 1'b1;
    @(negedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Issue one request, wait for its response within a bounded window and
  // record which cycles after acceptance saw reads and writes.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input logic noise, output int lat, output logic [31:0] rd, output logic e,
                        output logic [7:0] rmask, output logic [7:0] wmask);
    int guard;
    exp_addr = {a[31:2], 2'b00};
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f;
    @(posedge clk);
    #1;
    // Optional garbage on the request bus while busy; it must be ignored.
    req_valid  = noise;
    req_write  = 1'($urandom_range(0, 1));
    req_addr   = $urandom();
    req_wdata  = $urandom();
    req_funct3 = 3'($urandom_range(0, 7));
    lat = 0; rd = 32'd0; e = 1'b0; rmask = 8'd0; wmask = 8'd0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (dmem_read)  rmask[k] = 1'b1;
      if (dmem_write) wmask[k] = 1'b1;
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        e   = resp_err;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  // Reference: plain byte arithmetic on ref_mem.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       output int lat, output logic [31:0] rd, output logic e,
                       output logic [7:0] rmask, output logic [7:0] wmask);
    int nb;
    int off;
    bit legal;
    longint unsigned word64, mask, val;
    logic [31:0] word;
    nb = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : (f[1:0] == 2'd2) ? 4 : 0;
    off = int'(a[1:0]);
    if (w) legal = (f == 3'd0 || f == 3'd1 || f == 3'd2);
    else   legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    rd = 32'd0; rmask = 8'd0; wmask = 8'd0;
    if (!legal || nb == 0 || (off % nb) != 0) begin
      e = 1'b1;
      lat = 1;
    end else begin
      e = 1'b0;
      word = ref_mem[a[7:2]];
      if (!w) begin
        word64 = 64'(word);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val = (word64 >> (8 * off)) & mask;
        if (!f[2] && nb < 4 && ((val >> (8 * nb - 1)) & 64'd1) == 64'd1) val = val | ~mask;
        rd = val[31:0];
        lat = 2;
        rmask[1] = 1'b1;
      end else begin
        for (int i = 0; i < nb; i++) word[8 * (off + i) +: 8] = d[8 * i +: 8];
        ref_mem[a[7:2]] = word;
        if (nb == 4) begin
          lat = 2;
          wmask[1] = 1'b1;
        end else begin
          lat = 3;
          rmask[1] = 1'b1;
          wmask[2] = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [31:0] mem4;
    logic [7:0]  rm;
    logic [7:0]  wm;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int          lat, mlat;
    logic [31:0] rd, mrd;
    logic        e, me;
    logic [7:0]  rm, wm, mrm, mwm;
    logic        saw_resp, saw_wr;
    logic        w;
    logic [2:0]  f;
    logic [31:0] a, d;

    tbl[0]  = '{1'b0, 32'h12, 32'h0, 3'b000, 32'hFFFFFF99, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[1]  = '{1'b0, 32'h12, 32'h0, 3'b100, 32'h00000099, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[2]  = '{1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8899, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[3]  = '{1'b0, 32'h10, 32'h0, 3'b101, 32'h0000AABB, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[4]  = '{1'b0, 32'h10, 32'h0, 3'b010, 32'h8899AABB, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[5]  = '{1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF88, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[6]  = '{1'b0, 32'h12, 32'h0, 3'b101, 32'h00008899, 1'b0, 2, 32'h8899AABB, 8'h02, 8'h00};
    tbl[7]  = '{1'b1, 32'h11, 32'h12345677, 3'b000, 32'h0, 1'b0, 3, 32'h889977BB, 8'h02, 8'h04};
    tbl[8]  = '{1'b1, 32'h12, 32'h0000CAFE, 3'b001, 32'h0, 1'b0, 3, 32'hCAFE77BB, 8'h02, 8'h04};
    tbl[9]  = '{1'b0, 32'h10, 32'h0, 3'b010, 32'hCAFE77BB, 1'b0, 2, 32'hCAFE77BB, 8'h02, 8'h00};
    tbl[10] = '{1'b0, 32'h13, 32'h0, 3'b010, 32'h0, 1'b1, 1, 32'hCAFE77BB, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 32'h21, 32'h5555, 3'b001, 32'h0, 1'b1, 1, 32'hCAFE77BB, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 1, 32'hCAFE77BB, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 32'h10, 32'h1, 3'b100, 32'h0, 1'b1, 1, 32'hCAFE77BB, 8'h00, 8'h00};
    tbl[14] = '{1'b0, 32'h11, 32'h0, 3'b001, 32'h0, 1'b1, 1, 32'hCAFE77BB, 8'h00, 8'h00};
    tbl[15] = '{1'b1, 32'h12, 32'h1, 3'b010, 32'h0, 1'b1, 1, 32'hCAFE77BB, 8'h00, 8'h00};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom();
      poke(i, ref_mem[i]);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_dmem_read", 32'(dmem_read), 32'd0);
    check("rst_dmem_write", 32'(dmem_write), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_din", dmem_din, 32'd0);

    // SW: single write in the first cycle after accept, response in the second.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, lat, rd, e, rm, wm);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(e), 32'd0);
    check("sw_wmask", 32'(wm), 32'h02);
    check("sw_rmask", 32'(rm), 32'h00);
    check("sw_mem", mem[4], 32'hDEADBEEF);

    poke(4, 32'h8899AABB);
    for (int i = 0; i < 16; i++) begin
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, 1'b0, lat, rd, e, rm, wm);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].err));
      check($sformatf("vec%0d_rmask", i), 32'(rm), 32'(tbl[i].rm));
      check($sformatf("vec%0d_wmask", i), 32'(wm), 32'(tbl[i].wm));
      check($sformatf("vec%0d_mem", i), mem[4], tbl[i].mem4);
    end

    // Reset landing in the WRITE cycle of an SB cancels the write and response.
    poke(5, 32'h11223344);
    exp_addr = 32'h14;
    @(negedge clk);
    check("abort_ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h15; req_wdata = 32'hAA; req_funct3 = 3'b000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_dmem_write", 32'(dmem_write), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    saw_resp = resp_valid;
    saw_wr = dmem_write;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
      if (dmem_write) saw_wr = 1'b1;
    end
    check("abort_no_resp", 32'(saw_resp), 32'd0);
    check("abort_no_write", 32'(saw_wr), 32'd0);
    check("abort_mem", mem[5], 32'h11223344);

    // Randomized traffic against the byte-level model.
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = ($urandom() & 32'h0000_00FF) | (($urandom_range(0, 3) == 0) ? 32'hABCD_0000 : 32'h0);
      if ($urandom_range(0, 1) == 1) a = a & ((f[1:0] == 2'd2) ? ~32'd3 : (f[1:0] == 2'd1) ? ~32'd1 : ~32'd0);
      d = $urandom();
      model(w, a, d, f, mlat, mrd, me, mrm, mwm);
      do_req(w, a, d, f, 1'($urandom_range(0, 1)), lat, rd, e, rm, wm);
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(mlat));
      check($sformatf("rnd%0d_rdata", n), rd, mrd);
      check($sformatf("rnd%0d_err", n), 32'(e), 32'(me));
      check($sformatf("rnd%0d_rwmask", n), {16'd0, rm, wm}, {16'd0, mrm, mwm});
      check($sformatf("rnd%0d_mem", n), mem[a[7:2]], ref_mem[a[7:2]]);
    end

`ifdef MAU_ACCESS_COUNT_EN
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 1'b0, lat, rd, e, rm, wm);
    do_req(1'b0, 32'h11, 32'h0, 3'b100, 1'b0, lat, rd, e, rm, wm);
    do_req(1'b1, 32'h20, 32'h1234, 3'b001, 1'b0, lat, rd, e, rm, wm);
    do_req(1'b0, 32'h22, 32'h0, 3'b010, 1'b0, lat, rd, e, rm, wm);
    @(negedge clk);
    check("cnt_ld", 32'(ld_count), 32'd2);
    check("cnt_st", 32'(st_count), 32'd1);
    check("cnt_err", 32'(err_count), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("cnt_ld_rst", 32'(ld_count), 32'd0);
    check("cnt_st_rst", 32'(st_count), 32'd0);
    check("cnt_err_rst", 32'(err_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
